// File: rtl/moka_rv32i_sc_trace_buf.sv
// Instruction trace buffer for a single-cycle RV32I core: arm/trigger/capture
// control feeding a first-word-fall-through record FIFO with drop accounting.
module moka_rv32i_sc_trace_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    trig_en,
  input  logic [DATA_WIDTH-1:0]   trig_pc,
  input  logic [15:0]             cap_len,
  input  logic [DATA_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0]   instruction,
  input  logic                    RegWrite,
  input  logic [4:0]              rd,
  input  logic [DATA_WIDTH-1:0]   WD3,
  input  logic                    MemWrite,
  input  logic [DATA_WIDTH-1:0]   ALUResult,
  input  logic [DATA_WIDTH-1:0]   RD2,
  input  logic                    PCSrc,
  input  logic [DATA_WIDTH-1:0]   PCTarget,
  output logic                    tr_valid,
  input  logic                    tr_ready,
  output logic [DATA_WIDTH-1:0]   tr_pc,
  output logic [DATA_WIDTH-1:0]   tr_instr,
  output logic [DATA_WIDTH-1:0]   tr_data,
  output logic [DATA_WIDTH-1:0]   tr_addr,
  output logic [4:0]              tr_rd,
  output logic [3:0]              tr_flags,
  output logic [1:0]              state,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 4 * DATA_WIDTH + 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_remaining, w_remaining_nxt;
  logic              w_push_req;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic [REC_W-1:0]  r_mem [DEPTH];
  logic              r_gap;
  logic [15:0]       r_drop_cnt;
  logic [DATA_WIDTH-1:0] w_data, w_addr;
  logic [4:0]        w_rd;
  logic [REC_W-1:0]  w_rec, w_head;
  logic              w_full, w_pop, w_push_ok, w_drop;

  always_comb begin
    w_data = '0;
    w_addr = '0;
    w_rd   = '0;
    if (MemWrite)      w_data = RD2;
    else if (RegWrite) w_data = WD3;
    if (MemWrite)      w_addr = ALUResult;
    else if (PCSrc)    w_addr = PCTarget;
    if (RegWrite)      w_rd   = rd;
  end

  assign w_rec = {pc, instruction, w_data, w_addr, w_rd, r_gap, PCSrc, MemWrite, RegWrite};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // stop outranks start; a zero remaining count means capture is unlimited
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_push_req      = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start && !stop) begin
          w_state_nxt     = trig_en ? S_ARMED : S_CAPTURE;
          w_remaining_nxt = cap_len;
        end
      end
      S_ARMED: begin
        if (stop) begin
          w_state_nxt = S_DONE;
        end else if (pc == trig_pc) begin
          w_state_nxt = S_CAPTURE;
          w_push_req  = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (stop) w_state_nxt = S_DONE;
        else      w_push_req  = 1'b1;
      end
      default: ;
    endcase
    if (w_push_req && r_remaining != 16'd0) begin
      w_remaining_nxt = r_remaining - 16'd1;
      if (r_remaining == 16'd1) w_state_nxt = S_DONE;
    end
  end

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = (r_count != '0) && tr_ready;
  assign w_push_ok = w_push_req && (!w_full || w_pop);
  assign w_drop    = w_push_req && !w_push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_gap      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - (AW+1)'(1);
      if (w_drop) begin
        r_gap <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end else if (w_push_ok) begin
        r_gap <= 1'b0;
      end
    end
  end

  // storage needs no reset: an empty FIFO masks the head to zero
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_rec;
  end

  assign w_head   = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign {tr_pc, tr_instr, tr_data, tr_addr, tr_rd, tr_flags} = w_head;
  assign tr_valid = (r_count != '0);
  assign state    = r_state;
  assign count    = r_count;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_moka_rv32i_sc_trace_buf.sv
// Bench for moka_rv32i_sc_trace_buf: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_moka_rv32i_sc_trace_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int REC_W = 4 * DW + 9;

  logic            clk = 1'b0;
  logic            rst, start, stop, trig_en;
  logic [DW-1:0]   trig_pc;
  logic [15:0]     cap_len;
  logic [DW-1:0]   pc, instruction, WD3, ALUResult, RD2, PCTarget;
  logic            RegWrite, MemWrite, PCSrc;
  logic [4:0]      rd;
  logic            tr_valid, tr_ready;
  logic [DW-1:0]   tr_pc, tr_instr, tr_data, tr_addr;
  logic [4:0]      tr_rd;
  logic [3:0]      tr_flags;
  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [15:0]     drop_cnt;

  moka_rv32i_sc_trace_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .trig_en(trig_en),
    .trig_pc(trig_pc), .cap_len(cap_len), .pc(pc), .instruction(instruction),
    .RegWrite(RegWrite), .rd(rd), .WD3(WD3), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .RD2(RD2), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_pc(tr_pc), .tr_instr(tr_instr),
    .tr_data(tr_data), .tr_addr(tr_addr), .tr_rd(tr_rd), .tr_flags(tr_flags),
    .state(state), .count(count), .drop_cnt(drop_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DW-1:0] pc, instr, data, addr;
    logic [4:0]    rd;
    logic [3:0]    flags;
  } rec_t;

  logic [REC_W-1:0] exp_q[$];
  int  m_state;
  int  m_rem;
  bit  m_gap;
  int  m_drop;
  int  n_vec;
  int  n_err;

  task automatic model_step();
    rec_t r;
    bit   do_pop, push_req;
    int   nxt;
    if (rst) begin
      exp_q.delete();
      m_state = 0; m_rem = 0; m_gap = 0; m_drop = 0;
      return;
    end
    r.pc    = pc;
    r.instr = instruction;
    r.data  = MemWrite ? RD2 : (RegWrite ? WD3 : '0);
    r.addr  = MemWrite ? ALUResult : (PCSrc ? PCTarget : '0);
    r.rd    = RegWrite ? rd : 5'd0;
    r.flags = {m_gap, PCSrc, MemWrite, RegWrite};
    do_pop   = (exp_q.size() != 0) && tr_ready;
    push_req = 0;
    nxt      = m_state;
    if (stop && (m_state == 1 || m_state == 2)) nxt = 3;
    else if (!stop && start && (m_state == 0 || m_state == 3)) begin
      nxt   = trig_en ? 1 : 2;
      m_rem = cap_len;
    end else if (m_state == 1 && pc == trig_pc) begin
      nxt = 2; push_req = 1;
    end else if (m_state == 2 && !stop) push_req = 1;
    if (push_req && m_rem != 0) begin
      m_rem--;
      if (m_rem == 0) nxt = 3;
    end
    m_state = nxt;
    if (do_pop) void'(exp_q.pop_front());
    if (push_req) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back(r);
        m_gap = 0;
      end else begin
        m_gap = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    rec_t h;
    h = (exp_q.size() != 0) ? rec_t'(exp_q[0]) : '0;
    check("model state",    64'(state),    64'(m_state));
    check("model count",    64'(count),    64'(exp_q.size()));
    check("model tr_valid", 64'(tr_valid), 64'(exp_q.size() != 0));
    check("model drop_cnt", 64'(drop_cnt), 64'(m_drop));
    check("model tr_pc",    64'(tr_pc),    64'(h.pc));
    check("model tr_instr", 64'(tr_instr), 64'(h.instr));
    check("model tr_data",  64'(tr_data),  64'(h.data));
    check("model tr_addr",  64'(tr_addr),  64'(h.addr));
    check("model tr_rd",    64'(tr_rd),    64'(h.rd));
    check("model tr_flags", 64'(tr_flags), 64'(h.flags));
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; stop = 0; trig_en = 0; trig_pc = '0; cap_len = '0;
    pc = '0; instruction = '0; RegWrite = 0; rd = '0; WD3 = '0; MemWrite = 0;
    ALUResult = '0; RD2 = '0; PCSrc = 0; PCTarget = '0; tr_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  typedef struct {
    logic          start, stop, trig_en;
    logic [DW-1:0] trig_pc;
    logic [15:0]   cap_len;
    logic [DW-1:0] pc;
    logic          ready;
    logic [1:0]    e_state;
    int            e_count;
    logic [DW-1:0] e_pc;
    int            e_drop;
  } vec_t;

  vec_t tbl[14];
  int   reads;
  bit   ready_bias;

  initial begin
    n_vec = 0; n_err = 0;
    m_state = 0; m_rem = 0; m_gap = 0; m_drop = 0;
    //            start stop trig trig_pc  cap  pc       rdy st    cnt pc      drop
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,  16'd3, 32'h00, 1'b1, 2'd2, 0, 32'h0,  0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  16'd3, 32'h04, 1'b1, 2'd2, 1, 32'h04, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  16'd3, 32'h08, 1'b1, 2'd2, 1, 32'h08, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  16'd3, 32'h0C, 1'b1, 2'd3, 1, 32'h0C, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,  16'd3, 32'h10, 1'b1, 2'd3, 0, 32'h0,  0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h40, 16'd2, 32'h34, 1'b1, 2'd1, 0, 32'h0,  0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h40, 16'd2, 32'h38, 1'b1, 2'd1, 0, 32'h0,  0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h40, 16'd2, 32'h3C, 1'b1, 2'd1, 0, 32'h0,  0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h40, 16'd2, 32'h40, 1'b1, 2'd2, 1, 32'h40, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h40, 16'd2, 32'h44, 1'b1, 2'd3, 0, 32'h0,  0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0,  16'd2, 32'h48, 1'b1, 2'd3, 0, 32'h0,  0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h0,  16'd2, 32'h4C, 1'b1, 2'd3, 0, 32'h0,  0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 32'h0,  16'd1, 32'h50, 1'b1, 2'd2, 0, 32'h0,  0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,  16'd1, 32'h54, 1'b1, 2'd3, 1, 32'h54, 0};

    // reset values
    do_reset();
    do_reset();
    check("reset state",    64'(state),    64'd0);
    check("reset count",    64'(count),    64'd0);
    check("reset tr_valid", 64'(tr_valid), 64'd0);
    check("reset drop_cnt", 64'(drop_cnt), 64'd0);
    check("reset tr_pc",    64'(tr_pc),    64'd0);
    check("reset tr_flags", 64'(tr_flags), 64'd0);

    // vector table: immediate capture, trigger match, stop, stop+start
    foreach (tbl[i]) begin
      idle_inputs();
      start = tbl[i].start; stop = tbl[i].stop; trig_en = tbl[i].trig_en;
      trig_pc = tbl[i].trig_pc; cap_len = tbl[i].cap_len; pc = tbl[i].pc;
      instruction = 32'h13 + tbl[i].pc; tr_ready = tbl[i].ready;
      tick();
      check("tbl state",    64'(state),    64'(tbl[i].e_state));
      check("tbl count",    64'(count),    64'(tbl[i].e_count));
      check("tbl tr_valid", 64'(tr_valid), 64'(tbl[i].e_count != 0));
      check("tbl tr_pc",    64'(tr_pc),    64'(tbl[i].e_pc));
      check("tbl drop_cnt", 64'(drop_cnt), 64'(tbl[i].e_drop));
    end

    // store and register-write record field selection
    do_reset();
    start = 1; cap_len = 16'd2; tick(); start = 0;
    pc = 32'h200; MemWrite = 1; ALUResult = 32'h100; RD2 = 32'hDEAD;
    rd = 5'd7; WD3 = 32'h5555; PCSrc = 0; PCTarget = 32'h999;
    tick();
    idle_inputs();
    pc = 32'h204; RegWrite = 1; rd = 5'd5; WD3 = 32'h1234; PCSrc = 1; PCTarget = 32'h300;
    RD2 = 32'hBEEF; ALUResult = 32'h777;
    tick();
    check("store tr_addr",  64'(tr_addr),  64'h100);
    check("store tr_data",  64'(tr_data),  64'hDEAD);
    check("store tr_flags", 64'(tr_flags), 64'b0010);
    check("store tr_rd",    64'(tr_rd),    64'd0);
    check("store state",    64'(state),    64'd3);
    idle_inputs();
    tr_ready = 1;
    tick();
    check("regwr tr_data",  64'(tr_data),  64'h1234);
    check("regwr tr_addr",  64'(tr_addr),  64'h300);
    check("regwr tr_rd",    64'(tr_rd),    64'd5);
    check("regwr tr_flags", 64'(tr_flags), 64'b0101);

    // overflow: 20 records into 16 entries, then gap flag on first new record
    do_reset();
    start = 1; cap_len = 16'd20; tick(); start = 0;
    repeat (20) tick();
    check("ovf count",    64'(count),    64'd16);
    check("ovf drop_cnt", 64'(drop_cnt), 64'd4);
    check("ovf state",    64'(state),    64'd3);
    start = 1; cap_len = 16'd2; tr_ready = 1;
    reads = 0;
    for (int c = 0; c < 40 && reads < 18; c++) begin
      if (tr_valid && tr_ready) begin
        reads++;
        if (reads == 16) check("gap clear before", 64'(tr_flags[3]), 64'd0);
        if (reads == 17) check("gap on 17th",      64'(tr_flags[3]), 64'd1);
        if (reads == 18) check("gap cleared 18th", 64'(tr_flags[3]), 64'd0);
      end
      tick();
      start = 0;
    end
    check("ovf reads done", 64'(reads), 64'd18);

    // reset in the middle of a capture discards everything
    idle_inputs();
    start = 1; tick(); start = 0;
    repeat (5) tick();
    check("pre-rst count", 64'(count), 64'd5);
    check("pre-rst state", 64'(state), 64'd2);
    start = 1; pc = 32'h80; rst = 1;
    tick();
    idle_inputs();
    check("rst state",    64'(state),    64'd0);
    check("rst count",    64'(count),    64'd0);
    check("rst tr_valid", 64'(tr_valid), 64'd0);
    check("rst drop_cnt", 64'(drop_cnt), 64'd0);

    // full FIFO with simultaneous push and pop stays full without drops
    start = 1; tick(); start = 0;
    for (int k = 0; k < 16; k++) begin
      pc = 32'h1000 + 32'(k * 4);
      tick();
    end
    check("full count", 64'(count), 64'd16);
    tr_ready = 1;
    for (int k = 0; k < 8; k++) begin
      pc = 32'h2000 + 32'(k * 4);
      tick();
      check("full steady count", 64'(count),    64'd16);
      check("full steady drop",  64'(drop_cnt), 64'd0);
    end
    stop = 1; tick(); stop = 0;
    check("full stop state", 64'(state), 64'd3);

    // randomized traffic against the model
    ready_bias = 1;
    for (int i = 0; i < 700; i++) begin
      if (i % 100 == 0) ready_bias = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 99) == 0);
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 29) == 0);
      trig_en     = 1'($urandom_range(0, 1));
      trig_pc     = 32'h40;
      cap_len     = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 24));
      pc          = ($urandom_range(0, 3) == 0) ? 32'h40 : ($urandom() & 32'hFFFC);
      instruction = $urandom();
      RegWrite    = 1'($urandom_range(0, 1));
      rd          = 5'($urandom_range(0, 31));
      WD3         = $urandom();
      MemWrite    = 1'($urandom_range(0, 1));
      ALUResult   = $urandom();
      RD2         = $urandom();
      PCSrc       = 1'($urandom_range(0, 1));
      PCTarget    = $urandom();
      tr_ready    = ready_bias ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
